neopix_byte_tx: RTL and testbench

//   Downstream consumer of the SPI byte receiver: takes each received byte (DATA/READY strobe),

---
 rtl/neopix_byte_tx.sv | 166 ++++++++++++++++
 tb/tb_neopix_byte_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neopix_byte_tx.sv
// Byte FIFO feeding a WS2812 serialiser: bytes pushed on READY go out MSB-first as
// high/low-coded bit periods, with a latch gap ending each frame.
module neopix_byte_tx #(
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int TBIT         = 62,
  parameter int RESET_CYCLES = 3000,
  parameter int FIFO_DEPTH   = 16,
  localparam int AW          = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    DATA,
  input  logic          READY,
  output logic          DOUT,
  output logic          BUSY,
  output logic          FRAME_DONE,
  output logic          OVERFLOW,
  output logic [AW:0]   LEVEL,
  output logic [1:0]    state_dbg
);

  localparam int PW = $clog2(TBIT);
  localparam int GW = $clog2(RESET_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BIT   = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            sent_q, sent_d;
  logic            frame_done_d;
  logic            dout_d;
  logic            pop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level_q;
  logic            full, empty, push;
  logic [7:0]      head;
  logic [PW-1:0]   high_len;

  assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign push  = READY && !full;
  assign head  = mem[rd_ptr];

  // Fullness is judged on the occupancy before this edge, so a same-cycle pop
  // never makes room for the incoming byte.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (READY && full) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LATCH;
      phase_q    <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      gap_q      <= '0;
      sent_q     <= 1'b0;
      DOUT       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      gap_q      <= gap_d;
      sent_q     <= sent_d;
      DOUT       <= dout_d;
      FRAME_DONE <= frame_done_d;
    end
  end

  assign high_len = shreg_q[7] ? PW'(T1H) : PW'(T0H);
  assign dout_d   = (state_q == S_BIT) && (phase_q < high_len);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    gap_d        = gap_q;
    sent_d       = sent_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shreg_d  = head;
          bitcnt_d = 3'd7;
          phase_d  = '0;
          state_d  = S_BIT;
        end
      end
      S_BIT: begin
        if (phase_q == PW'(TBIT - 1)) begin
          phase_d = '0;
          if (bitcnt_q != 3'd0) begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q - 3'd1;
          end else if (!empty) begin
            pop      = 1'b1;
            shreg_d  = head;
            bitcnt_d = 3'd7;
          end else begin
            gap_d   = '0;
            sent_d  = 1'b1;
            state_d = S_LATCH;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LATCH: begin
        // Only a gap that follows transmitted data may be cut short; the post-reset
        // gap always runs to completion so the chain is latched before new data.
        if (gap_q == GW'(RESET_CYCLES - 1)) begin
          frame_done_d = sent_q;
          sent_d       = 1'b0;
          state_d      = S_IDLE;
        end else if (sent_q && !empty) begin
          pop      = 1'b1;
          shreg_d  = head;
          bitcnt_d = 3'd7;
          phase_d  = '0;
          state_d  = S_BIT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_LATCH;
    endcase
  end

  assign BUSY      = (state_q != S_IDLE);
  assign LEVEL     = level_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_neopix_byte_tx.sv
// Bench for neopix_byte_tx: a negedge line monitor decodes DOUT into bytes and bit
// timings, and scenario tasks compare them with the bytes the host pushed.
module tb_neopix_byte_tx;
  localparam int T0H = 20, T1H = 40, TBIT = 62, RC = 3000, DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       dout, busy, frame_done, overflow;
  logic [4:0] level;
  logic [1:0] state_dbg;

  int nchk = 0;
  int nfail = 0;

  neopix_byte_tx #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RESET_CYCLES(RC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .DATA(data), .READY(ready), .DOUT(dout), .BUSY(busy),
    .FRAME_DONE(frame_done), .OVERFLOW(overflow), .LEVEL(level), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Line monitor: measures high/low run lengths and rebuilds bytes from them.
  int         cyc = 0, hi_len = 0, lo_len = RC, last_hi = 0, nbits = 0, bits_in_byte = 0;
  int         irr_cnt = 0, last_gap_low = 0, fd_cnt = 0, bad_hi = 0, first_rise = 0, last_rise = 0;
  logic       prev_d = 1'b0, have_bit = 1'b0;
  logic [7:0] acc = 8'h00;
  int         hi_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (frame_done === 1'b1) fd_cnt++;
    if (rst) begin
      prev_d = 1'b0; hi_len = 0; lo_len = RC; have_bit = 1'b0; bits_in_byte = 0; acc = 8'h00;
    end else if (dout && !prev_d) begin
      if (have_bit && lo_len < RC && (last_hi + lo_len) != TBIT) begin
        irr_cnt++;
        last_gap_low = lo_len - (TBIT - last_hi);
      end
      if (!have_bit || lo_len >= RC) first_rise = cyc;
      last_rise = cyc; hi_len = 1; prev_d = 1'b1;
    end else if (dout) begin
      hi_len++;
    end else if (prev_d) begin
      last_hi = hi_len; hi_q.push_back(hi_len); have_bit = 1'b1; nbits++;
      if (hi_len != T0H && hi_len != T1H) bad_hi++;
      acc = {acc[6:0], (hi_len == T1H)};
      bits_in_byte++;
      if (bits_in_byte == 8) begin got_q.push_back(acc); bits_in_byte = 0; end
      lo_len = 1; prev_d = 1'b0;
    end else begin
      lo_len++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    data = b; ready = 1'b1; step(); ready = 1'b0;
  endtask

  task automatic wait_frame(input int fd0, input int budget);
    for (int i = 0; i < budget && fd_cnt == fd0; i++) step();
    nchk++;
    if (fd_cnt !== fd0 + 1) begin
      nfail++; $display("FAIL frame_wait: frame_done count %0d, required %0d", fd_cnt - fd0, 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); step(); rst = 1'b0;
    nchk++; if (dout !== 1'b0) begin nfail++; $display("FAIL reset_dout: got %b want 0", dout); end
    nchk++; if (level !== 5'd0) begin nfail++; $display("FAIL reset_level: got %0d want 0", level); end
    nchk++; if (overflow !== 1'b0) begin nfail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL reset_busy: got %b want 1", busy); end
    for (int i = 1; i < RC; i++) step();
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL reset_gap_busy: got %b want 1", busy); end
    step();
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_gap_end: got %b want 0", busy); end
    nchk++; if (fd_cnt !== 0) begin nfail++; $display("FAIL reset_no_fd: got %0d want 0", fd_cnt); end
  endtask

  task automatic test_single_byte();
    int fd0, irr0;
    int exp_hi[8];
    logic [7:0] b;
    b = 8'hA5;
    for (int i = 0; i < 8; i++) exp_hi[i] = b[7-i] ? T1H : T0H;
    hi_q.delete(); got_q.delete(); fd0 = fd_cnt; irr0 = irr_cnt;
    push_byte(b);
    nchk++; if (dout !== 1'b0) begin nfail++; $display("FAIL latency_k1: dout %b want 0", dout); end
    step();
    nchk++; if (dout !== 1'b0) begin nfail++; $display("FAIL latency_k1b: dout %b want 0", dout); end
    step();
    nchk++; if (dout !== 1'b1) begin nfail++; $display("FAIL latency_k2: dout %b want 1", dout); end
    wait_frame(fd0, 8 * TBIT + RC + 20);
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL single_busy: got %b want 0", busy); end
    nchk++;
    if (hi_q.size() != 8) begin
      nfail++; $display("FAIL single_nbits: got %0d want 8", hi_q.size());
    end else begin
      for (int i = 0; i < 8; i++)
        if (hi_q[i] != exp_hi[i]) begin
          nfail++; $display("FAIL single_high_%0d: got %0d want %0d", i, hi_q[i], exp_hi[i]); break;
        end
    end
    nchk++; if (got_q.size() != 1 || got_q[0] !== b) begin nfail++; $display("FAIL single_byte: got %0d bytes", got_q.size()); end
    nchk++; if (irr_cnt !== irr0) begin nfail++; $display("FAIL single_period: irregular %0d want 0", irr_cnt - irr0); end
    for (int i = 0; i < 20; i++) step();
    nchk++; if (fd_cnt !== fd0 + 1) begin nfail++; $display("FAIL single_fd_once: got %0d want 1", fd_cnt - fd0); end
  endtask

  task automatic test_back_to_back();
    int fd0, irr0, nb0;
    logic [7:0] v[3];
    v[0] = 8'hFF; v[1] = 8'h00; v[2] = 8'h81;
    got_q.delete(); exp_q.delete(); fd0 = fd_cnt; irr0 = irr_cnt; nb0 = nbits;
    for (int j = 0; j < 3; j++) begin
      push_byte(v[j]); exp_q.push_back(v[j]);
      if (j < 2) for (int i = 0; i < 9; i++) step();
    end
    wait_frame(fd0, 3 * 8 * TBIT + RC + 40);
    nchk++; if (nbits - nb0 !== 24) begin nfail++; $display("FAIL b2b_nbits: got %0d want 24", nbits - nb0); end
    nchk++; if (irr_cnt !== irr0) begin nfail++; $display("FAIL b2b_gap: irregular %0d want 0", irr_cnt - irr0); end
    nchk++; if (last_rise - first_rise + TBIT !== 24 * TBIT) begin
      nfail++; $display("FAIL b2b_span: got %0d want %0d", last_rise - first_rise + TBIT, 24 * TBIT); end
    nchk++; if (bad_hi !== 0) begin nfail++; $display("FAIL b2b_highs: bad high runs %0d want 0", bad_hi); end
    nchk++;
    if (got_q.size() != exp_q.size()) begin
      nfail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          nfail++; $display("FAIL b2b_byte_%0d: got %h want %h", i, got_q[i], exp_q[i]); break;
        end
    end
  endtask

  task automatic test_stretch();
    int fd0, irr0;
    got_q.delete(); exp_q.delete(); fd0 = fd_cnt; irr0 = irr_cnt;
    exp_q.push_back(8'($urandom_range(0, 255))); exp_q.push_back(8'($urandom_range(0, 255)));
    push_byte(exp_q[0]);
    for (int i = 0; i < 8 * TBIT + 10 && state_dbg != 2'd2; i++) step();
    for (int i = 0; i < 999; i++) step();
    nchk++; if (fd_cnt !== fd0) begin nfail++; $display("FAIL stretch_early_fd: got %0d want 0", fd_cnt - fd0); end
    push_byte(exp_q[1]);
    wait_frame(fd0, 8 * TBIT + RC + 40);
    nchk++; if (irr_cnt - irr0 !== 1 || last_gap_low < 995 || last_gap_low > 1010) begin
      nfail++; $display("FAIL stretch_gap: irregular %0d low %0d want 1 and ~1000", irr_cnt - irr0, last_gap_low); end
    nchk++; if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      nfail++; $display("FAIL stretch_bytes: got %0d bytes want 2 matching", got_q.size()); end
  endtask

  task automatic test_overflow();
    int fd0;
    logic [7:0] b;
    rst = 1'b1; step(); rst = 1'b0;
    got_q.delete(); exp_q.delete(); fd0 = fd_cnt;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < DEPTH) exp_q.push_back(b);
      data = b; ready = 1'b1; step();
    end
    ready = 1'b0;
    nchk++; if (level !== 5'(DEPTH)) begin nfail++; $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); end
    nchk++; if (overflow !== 1'b1) begin nfail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    wait_frame(fd0, 2 * RC + DEPTH * 8 * TBIT + 100);
    nchk++;
    if (got_q.size() != exp_q.size()) begin
      nfail++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          nfail++; $display("FAIL ovf_byte_%0d: got %h want %h", i, got_q[i], exp_q[i]); break;
        end
    end
  endtask

  task automatic test_full_pop();
    int fd0;
    rst = 1'b1; step(); rst = 1'b0;
    got_q.delete(); exp_q.delete(); fd0 = fd_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      data = exp_q[i]; ready = 1'b1; step();
    end
    ready = 1'b0;
    nchk++; if (level !== 5'(DEPTH) || overflow !== 1'b0) begin
      nfail++; $display("FAIL fullpop_pre: level %0d ovf %b want %0d 0", level, overflow, DEPTH); end
    for (int i = 0; i < RC + 10 && state_dbg != 2'd0; i++) step();
    push_byte(8'($urandom_range(0, 255)));
    nchk++; if (level !== 5'(DEPTH - 1)) begin nfail++; $display("FAIL fullpop_level: got %0d want %0d", level, DEPTH - 1); end
    nchk++; if (overflow !== 1'b1) begin nfail++; $display("FAIL fullpop_ovf: got %b want 1", overflow); end
    wait_frame(fd0, RC + DEPTH * 8 * TBIT + 100);
    nchk++;
    if (got_q.size() != exp_q.size()) begin
      nfail++; $display("FAIL fullpop_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          nfail++; $display("FAIL fullpop_byte_%0d: got %h want %h", i, got_q[i], exp_q[i]); break;
        end
    end
  endtask

  task automatic test_reset_mid();
    int fd0, nb0, busy_bad;
    for (int i = 0; i < 6; i++) begin data = 8'($urandom_range(0, 255)); ready = 1'b1; step(); end
    ready = 1'b0;
    for (int i = 0; i < 8 * TBIT && !(bits_in_byte == 3 && dout === 1'b1); i++) step();
    nchk++; if (!(bits_in_byte == 3 && dout === 1'b1)) begin
      nfail++; $display("FAIL mid_reach_bit3: bits %0d dout %b want 3 1", bits_in_byte, dout); end
    nchk++; if (level !== 5'd5 || overflow !== 1'b1) begin
      nfail++; $display("FAIL mid_pre: level %0d ovf %b want 5 1", level, overflow); end
    rst = 1'b1; step(); rst = 1'b0;
    fd0 = fd_cnt; nb0 = nbits; busy_bad = 0;
    nchk++; if (dout !== 1'b0) begin nfail++; $display("FAIL mid_dout: got %b want 0", dout); end
    nchk++; if (level !== 5'd0) begin nfail++; $display("FAIL mid_level: got %0d want 0", level); end
    nchk++; if (overflow !== 1'b0) begin nfail++; $display("FAIL mid_ovf: got %b want 0", overflow); end
    for (int i = 1; i < RC; i++) begin step(); if (busy !== 1'b1) busy_bad++; end
    nchk++; if (busy_bad !== 0) begin nfail++; $display("FAIL mid_busy: low cycles %0d want 0", busy_bad); end
    step();
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL mid_busy_end: got %b want 0", busy); end
    nchk++; if (fd_cnt !== fd0 || nbits !== nb0) begin
      nfail++; $display("FAIL mid_quiet: fd %0d bits %0d want 0 0", fd_cnt - fd0, nbits - nb0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_stretch();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
